// File: rtl/ps2_keycode_fifo_rx.sv
// PS/2 keyboard receiver: synchronise + glitch-filter the bus, decode 11-bit frames,
// fold E0/F0 prefixes into flags and queue key events in a show-ahead FIFO.
module ps2_keycode_fifo_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int DECODE_PFX  = 1
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       ps2clk,
    input  logic       ps2data,
    input  logic       rd_en,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_valid,
    output logic       new_key_strobe,
    output logic       fifo_full,
    output logic       overflow,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // input path
    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          clk_f, clk_f_d;
    logic [FW-1:0] fcnt;
    logic          fall;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
            fcnt    <= '0;
        end else begin
            clk_s1  <= ps2clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2data;
            data_s2 <= data_s1;
            clk_f_d <= clk_f;
            // filtered clock only follows after FILTER_LEN consecutive differing samples
            if (clk_s2 == clk_f) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                clk_f <= clk_s2;
                fcnt  <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    assign fall = clk_f_d & ~clk_f;

    // frame decoder
    state_t        state, state_n;
    logic [2:0]    bitcnt, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          par_q, par_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          byte_ok, perr, ferr;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state  <= IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            par_q  <= 1'b0;
            tcnt   <= '0;
        end else begin
            state  <= state_n;
            bitcnt <= bit_n;
            shreg  <= sh_n;
            par_q  <= par_n;
            tcnt   <= tcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        bit_n   = bitcnt;
        sh_n    = shreg;
        par_n   = par_q;
        byte_ok = 1'b0;
        perr    = 1'b0;
        ferr    = 1'b0;
        tcnt_n  = (state == IDLE || fall) ? '0 : tcnt + TW'(1);
        case (state)
            IDLE: if (fall && !data_s2) begin
                state_n = DATA;
                bit_n   = '0;
            end
            DATA: if (fall) begin
                sh_n  = {data_s2, shreg[7:1]};
                bit_n = bitcnt + 3'd1;
                if (bitcnt == 3'd7) state_n = PARITY;
            end
            PARITY: if (fall) begin
                par_n   = data_s2;
                state_n = STOP;
            end
            STOP: if (fall) begin
                state_n = IDLE;
                if (!(^{shreg, par_q}))  perr    = 1'b1;
                else if (!data_s2)       ferr    = 1'b1;
                else                     byte_ok = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state_n = IDLE;
            ferr    = 1'b1;
            tcnt_n  = '0;
        end
    end

    // prefix folding
    logic     ext_q, brk_q;
    logic     is_pfx, push;
    key_evt_t wr_evt;

    assign is_pfx = (DECODE_PFX != 0) && (shreg == 8'hE0 || shreg == 8'hF0);
    assign push   = byte_ok && !is_pfx;
    assign wr_evt = (DECODE_PFX != 0) ? key_evt_t'{ext_q, brk_q, shreg}
                                      : key_evt_t'{1'b0, 1'b0, shreg};

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (perr || ferr || push) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (byte_ok && is_pfx) begin
            if (shreg == 8'hE0) ext_q <= 1'b1;
            else                brk_q <= 1'b1;
        end
    end

    // event FIFO
    key_evt_t      mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          pop, do_push;

    assign pop     = rd_en && (count != '0);
    assign do_push = push && (count != CW'(FIFO_DEPTH) || pop);

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            new_key_strobe <= 1'b0;
            overflow       <= 1'b0;
            parity_err     <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wr_evt;
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            if (do_push && !pop)      count <= count + CW'(1);
            else if (!do_push && pop) count <= count - CW'(1);
            new_key_strobe <= do_push;
            if (push && !do_push) overflow <= 1'b1;
            parity_err <= perr;
            frame_err  <= ferr;
        end
    end

    assign key_code    = mem[rptr].code;
    assign key_ext     = mem[rptr].ext;
    assign key_release = mem[rptr].brk;
    assign key_valid   = (count != '0);
    assign fifo_full   = (count == CW'(FIFO_DEPTH));
    assign rx_busy     = (state != IDLE);

endmodule
